// File: rtl/hazard_unit.sv
// Hazard detection for a 5-stage pipeline with ID-resolved branches and a
// multi-cycle multiply/divide unit; also keeps stall and flush statistics.
module hazard_unit #(
    parameter int MDU_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        useRs_ID,
    input  logic        useRt_ID,
    input  logic        isBranch_ID,
    input  logic        branchTaken_ID,
    input  logic        isMduRead_ID,
    input  logic [4:0]  rd_ID_EX,
    input  logic        ctrlRegWrite_ID_EX,
    input  logic        ctrlMemRead_ID_EX,
    input  logic [4:0]  rd_EX_MEM,
    input  logic        ctrlMemRead_EX_MEM,
    input  logic        mduStart_ID_EX,
    output logic        stall,
    output logic        flushIF_ID,
    output logic        mduBusy,
    output logic [31:0] stallCycles,
    output logic [15:0] flushCount
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

    localparam logic [5:0] CNT_LOAD = 6'(MDU_LATENCY - 1);

    mdu_state_t state, state_next;
    logic [5:0] cnt, cnt_next;
    logic       load_use, br_dep_ex, br_dep_mem, mdu_wait;

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic src_match(input logic [4:0] x);
        return (x != 5'd0) &&
               ((useRs_ID && (rs_ID == x)) || (useRt_ID && (rt_ID == x)));
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign load_use   = ctrlMemRead_ID_EX && src_match(rd_ID_EX);
    assign br_dep_ex  = isBranch_ID && ctrlRegWrite_ID_EX && src_match(rd_ID_EX);
    assign br_dep_mem = isBranch_ID && ctrlMemRead_EX_MEM && src_match(rd_EX_MEM);
    assign mdu_wait   = isMduRead_ID && mduBusy;

    assign stall      = !rst && (load_use || br_dep_ex || br_dep_mem || mdu_wait);
    assign flushIF_ID = !rst && branchTaken_ID && isBranch_ID && !stall;
    assign mduBusy    = (state == BUSY);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (mduStart_ID_EX) begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
        end else if (state == BUSY) begin
            if (cnt == 6'd0) begin
                state_next = IDLE;
            end else begin
                cnt_next = cnt - 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 6'd0;
            stallCycles <= 32'd0;
            flushCount  <= 16'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stall) stallCycles <= sat_inc32(stallCycles);
            if (flushIF_ID) flushCount <= sat_inc16(flushCount);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed cycles push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_ID, rt_ID, rd_ID_EX, rd_EX_MEM;
    logic        useRs_ID, useRt_ID, isBranch_ID, branchTaken_ID, isMduRead_ID;
    logic        ctrlRegWrite_ID_EX, ctrlMemRead_ID_EX, ctrlMemRead_EX_MEM;
    logic        mduStart_ID_EX;
    logic        stall, flushIF_ID, mduBusy;
    logic [31:0] stallCycles;
    logic [15:0] flushCount;

    hazard_unit #(.MDU_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .rs_ID(rs_ID), .rt_ID(rt_ID),
        .useRs_ID(useRs_ID), .useRt_ID(useRt_ID),
        .isBranch_ID(isBranch_ID), .branchTaken_ID(branchTaken_ID),
        .isMduRead_ID(isMduRead_ID),
        .rd_ID_EX(rd_ID_EX), .ctrlRegWrite_ID_EX(ctrlRegWrite_ID_EX),
        .ctrlMemRead_ID_EX(ctrlMemRead_ID_EX),
        .rd_EX_MEM(rd_EX_MEM), .ctrlMemRead_EX_MEM(ctrlMemRead_EX_MEM),
        .mduStart_ID_EX(mduStart_ID_EX),
        .stall(stall), .flushIF_ID(flushIF_ID), .mduBusy(mduBusy),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic        fl;
        logic        bz;
        logic [31:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk({e.name, ".stall"}, 32'(stall), 32'(e.st));
            chk({e.name, ".flush"}, 32'(flushIF_ID), 32'(e.fl));
            chk({e.name, ".busy"}, 32'(mduBusy), 32'(e.bz));
            chk({e.name, ".stallCycles"}, stallCycles, e.sc);
            chk({e.name, ".flushCount"}, 32'(flushCount), 32'(e.fc));
        end
    end

    task automatic idle();
        rs_ID = 0; rt_ID = 0; useRs_ID = 0; useRt_ID = 0;
        isBranch_ID = 0; branchTaken_ID = 0; isMduRead_ID = 0;
        rd_ID_EX = 0; ctrlRegWrite_ID_EX = 0; ctrlMemRead_ID_EX = 0;
        rd_EX_MEM = 0; ctrlMemRead_EX_MEM = 0; mduStart_ID_EX = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string n, input logic st, input logic fl,
                              input logic bz, input logic [31:0] sc, input logic [15:0] fc);
        exp_t e;
        e.name = n; e.st = st; e.fl = fl; e.bz = bz; e.sc = sc; e.fc = fc;
        expq.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Reset held: a load-use and taken branch must not stall or flush.
        step();
        rd_ID_EX = 5; ctrlMemRead_ID_EX = 1; ctrlRegWrite_ID_EX = 1;
        rs_ID = 5; useRs_ID = 1; isBranch_ID = 1; branchTaken_ID = 1;
        expect_out("reset", 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // Load-use: lw r5 in EX, add reads r5.
        rd_ID_EX = 5; ctrlMemRead_ID_EX = 1; ctrlRegWrite_ID_EX = 1;
        rs_ID = 5; useRs_ID = 1;
        expect_out("lu_c1", 1, 0, 0, 0, 0);
        step();
        rd_EX_MEM = 5; ctrlMemRead_EX_MEM = 1; rs_ID = 5; useRs_ID = 1;
        expect_out("lu_c2", 0, 0, 0, 1, 0);

        // Register zero never hazards.
        step();
        rd_ID_EX = 0; ctrlMemRead_ID_EX = 1; ctrlRegWrite_ID_EX = 1;
        rs_ID = 0; useRs_ID = 1;
        expect_out("r0", 0, 0, 0, 1, 0);

        // Load to taken branch: two stall cycles, flush in the third.
        step();
        rd_ID_EX = 8; ctrlMemRead_ID_EX = 1; ctrlRegWrite_ID_EX = 1;
        rt_ID = 8; useRt_ID = 1; isBranch_ID = 1; branchTaken_ID = 1;
        expect_out("lb_c1", 1, 0, 0, 1, 0);
        step();
        rd_EX_MEM = 8; ctrlMemRead_EX_MEM = 1;
        rt_ID = 8; useRt_ID = 1; isBranch_ID = 1; branchTaken_ID = 1;
        expect_out("lb_c2", 1, 0, 0, 2, 0);
        step();
        rt_ID = 8; useRt_ID = 1; isBranch_ID = 1; branchTaken_ID = 1;
        expect_out("lb_c3", 0, 1, 0, 3, 0);
        step();
        expect_out("lb_c4", 0, 0, 0, 3, 1);

        // ALU result to a not-taken branch: one stall cycle, no flush.
        step();
        rd_ID_EX = 9; ctrlRegWrite_ID_EX = 1;
        rs_ID = 9; useRs_ID = 1; isBranch_ID = 1;
        expect_out("ab_c1", 1, 0, 0, 3, 1);
        step();
        rd_EX_MEM = 9; rs_ID = 9; useRs_ID = 1; isBranch_ID = 1;
        expect_out("ab_c2", 0, 0, 0, 4, 1);

        // MDU wait, latency 4: start at cycle 0, mflo waits cycles 1-4.
        step();
        mduStart_ID_EX = 1;
        expect_out("mdu_c0", 0, 0, 0, 4, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            isMduRead_ID = 1;
            expect_out($sformatf("mdu_c%0d", i), 1, 0, 1, 32'(3 + i), 1);
        end
        step();
        isMduRead_ID = 1;
        expect_out("mdu_c5", 0, 0, 0, 8, 1);

        // Reset in the second BUSY cycle, with a competing start.
        step();
        mduStart_ID_EX = 1;
        expect_out("rb_c0", 0, 0, 0, 8, 1);
        step();
        expect_out("rb_c1", 0, 0, 1, 8, 1);
        step();
        rst = 1'b1; mduStart_ID_EX = 1; isMduRead_ID = 1;
        expect_out("rb_c2", 0, 0, 1, 8, 1);
        step();
        rst = 1'b0; isMduRead_ID = 1;
        expect_out("rb_c3", 0, 0, 0, 0, 0);
        step();
        expect_out("rb_c4", 0, 0, 0, 0, 0);

        // Drive flushes until the flush counter saturates.
        for (int i = 0; i < 65535; i++) begin
            step();
            isBranch_ID = 1; branchTaken_ID = 1;
        end
        step();
        isBranch_ID = 1; branchTaken_ID = 1;
        expect_out("sat_c1", 0, 1, 0, 0, 16'hFFFF);
        step();
        isBranch_ID = 1; branchTaken_ID = 1;
        expect_out("sat_c2", 0, 1, 0, 0, 16'hFFFF);
        step();
        expect_out("sat_c3", 0, 0, 0, 0, 16'hFFFF);

        begin
            int waited;
            waited = 0;
            while (expq.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            checks++;
            if (expq.size() > 0) begin
                failures++;
                $display("FAIL drain: %0d entries left, expected 0", expq.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
